// File: rtl/hx2003_pulse_pkg.sv
// Shared constants for the pulse-train transmitter: register map, bit
// positions, symbol field layout, bus size encoding and FSM states.
package hx2003_pulse_pkg;

  localparam logic [5:0] ADDR_CTRL     = 6'h00;
  localparam logic [5:0] ADDR_CARRIER  = 6'h04;
  localparam logic [5:0] ADDR_PRESCALE = 6'h08;
  localparam logic [5:0] ADDR_FIFO     = 6'h0C;
  localparam logic [5:0] ADDR_STATUS   = 6'h10;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_ABORT    = 1;
  localparam int unsigned CTRL_IDLE_LVL = 2;
  localparam int unsigned CTRL_INVERT   = 3;
  localparam int unsigned CTRL_IE_DONE  = 4;
  localparam int unsigned CTRL_IE_LOW   = 5;

  localparam int unsigned STS_BUSY      = 0;
  localparam int unsigned STS_EMPTY     = 1;
  localparam int unsigned STS_FULL      = 2;
  localparam int unsigned STS_OVF       = 3;
  localparam int unsigned STS_DONE      = 4;
  localparam int unsigned STS_LOW       = 5;
  localparam int unsigned STS_COUNT_LSB = 8;

  localparam int unsigned SYM_LEVEL = 15;
  localparam int unsigned SYM_CAREN = 14;

  localparam logic [1:0] BUS_W8   = 2'b00;
  localparam logic [1:0] BUS_W16  = 2'b01;
  localparam logic [1:0] BUS_W32  = 2'b10;
  localparam logic [1:0] BUS_NONE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Byte-lane mask covered by a write of the given size.
  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      BUS_W8:  m = 32'h0000_00FF;
      BUS_W16: m = 32'h0000_FFFF;
      BUS_W32: m = 32'hFFFF_FFFF;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hx2003_symbol_fifo.sv
// Synchronous symbol FIFO with flush; a push and a pop in the same cycle
// are both accepted even when full.
module hx2003_symbol_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | i_pop);

  // Storage write.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hx2003_pulse_seq_tx.sv
// Programmable pulse-train transmitter: plays queued {level, carrier_en,
// duration} symbols on uo_out[7] using a prescaled tick and optional carrier.
module hx2003_pulse_seq_tx
  import hx2003_pulse_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DUR_W      = 12,
  parameter int unsigned CARRIER_W  = 16,
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned LOW_WM     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = DUR_W + 2;

  state_t                r_state;
  logic [5:2]            r_cfg;
  logic [CARRIER_W-1:0]  r_carrier;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_ovf;
  logic                  r_done;
  logic [DUR_W-1:0]      r_dur;
  logic [PRESCALE_W-1:0] r_pre;
  logic [CARRIER_W-1:0]  r_car;
  logic                  r_phase;
  logic                  r_lvl;
  logic                  r_caren;
  logic                  r_pin;
  logic                  r_busy_q;

  logic        w_wr;
  logic [31:0] w_mask;
  logic        w_start;
  logic        w_abort;
  logic        w_push;
  logic        w_pop;
  logic        w_sts_wr;
  logic [SW-1:0] w_push_data;
  logic [SW-1:0] w_head;
  logic [DUR_W-1:0] w_head_dur;
  logic        w_full;
  logic        w_empty;
  logic [CW-1:0] w_count;
  logic        w_busy;
  logic        w_low;
  logic        w_last;
  logic        w_idle_pin;
  logic        w_ovf_set;
  logic        w_done_set;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_wr        = (data_write_n != BUS_NONE);
  assign w_mask      = lane_mask(data_write_n);
  assign w_start     = w_wr && (address == ADDR_CTRL) && data_in[CTRL_START];
  assign w_abort     = w_wr && (address == ADDR_CTRL) && data_in[CTRL_ABORT];
  assign w_push      = w_wr && (address == ADDR_FIFO);
  assign w_sts_wr    = w_wr && (address == ADDR_STATUS);
  assign w_push_data = {data_in[SYM_LEVEL], data_in[SYM_CAREN], data_in[DUR_W-1:0]};
  assign w_head_dur  = w_head[DUR_W-1:0];
  assign w_pop       = (r_state == S_LOAD) && !w_abort;
  assign w_busy      = (r_state != S_IDLE);
  assign w_low       = w_busy && (32'(w_count) <= LOW_WM);
  assign w_last      = (r_state == S_RUN) && (r_pre == '0) && (r_dur == DUR_W'(1));
  assign w_idle_pin  = r_cfg[CTRL_IDLE_LVL] ^ r_cfg[CTRL_INVERT];
  assign w_ovf_set   = w_push && w_full && !w_pop && !w_abort;
  assign w_done_set  = w_last && w_empty && !w_abort;

  assign uo_out         = {r_pin, r_busy_q, 6'b0};
  assign data_ready     = 1'b1;
  assign data_out       = w_rdata;
  assign user_interrupt = (r_done & r_cfg[CTRL_IE_DONE]) | (w_low & r_cfg[CTRL_IE_LOW]);
  assign w_unused       = ^{ui_in, data_read_n, data_in[31:16], w_mask[31:16]};

  hx2003_symbol_fifo #(
    .WIDTH (SW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_abort),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Configuration registers with byte-lane merging.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg      <= '0;
      r_carrier  <= '0;
      r_prescale <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_CTRL:     r_cfg <= data_in[5:2];
        ADDR_CARRIER:  r_carrier <= (r_carrier & ~w_mask[CARRIER_W-1:0]) |
                                    (data_in[CARRIER_W-1:0] & w_mask[CARRIER_W-1:0]);
        ADDR_PRESCALE: r_prescale <= (r_prescale & ~w_mask[PRESCALE_W-1:0]) |
                                     (data_in[PRESCALE_W-1:0] & w_mask[PRESCALE_W-1:0]);
        default: ;
      endcase
    end
  end

  // Sticky OVF/DONE flags, set wins over a same-cycle W1 clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_ovf_set)                         r_ovf <= 1'b1;
      else if (w_sts_wr && data_in[STS_OVF]) r_ovf <= 1'b0;
      if (w_done_set)                         r_done <= 1'b1;
      else if (w_sts_wr && data_in[STS_DONE]) r_done <= 1'b0;
    end
  end

  // Sequencer: symbol load, prescaled duration count and carrier phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dur   <= '0;
      r_pre   <= '0;
      r_car   <= '0;
      r_phase <= 1'b0;
      r_lvl   <= 1'b0;
      r_caren <= 1'b0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start && !w_empty) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_lvl   <= w_head[SW-1];
          r_caren <= w_head[SW-2];
          r_dur   <= (w_head_dur == '0) ? DUR_W'(1) : w_head_dur;
          r_pre   <= r_prescale;
          r_car   <= r_carrier;
          r_phase <= 1'b1;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_pre == '0) begin
            r_pre <= r_prescale;
            if (r_dur == DUR_W'(1)) r_state <= w_empty ? S_IDLE : S_LOAD;
            else                    r_dur   <= r_dur - DUR_W'(1);
          end else begin
            r_pre <= r_pre - PRESCALE_W'(1);
          end
          if (r_car == '0) begin
            r_car   <= r_carrier;
            r_phase <= ~r_phase;
          end else begin
            r_car <= r_car - CARRIER_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Registered pin and busy; LOAD holds the pin so the symbol before a
  // reload stays visible for that extra cycle. ABORT forces idle at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pin    <= 1'b0;
      r_busy_q <= 1'b0;
    end else if (w_abort) begin
      r_pin    <= w_idle_pin;
      r_busy_q <= 1'b0;
    end else begin
      r_busy_q <= w_busy;
      case (r_state)
        S_IDLE:  r_pin <= w_idle_pin;
        S_RUN:   r_pin <= (r_lvl & (r_caren ? r_phase : 1'b1)) ^ r_cfg[CTRL_INVERT];
        default: r_pin <= r_pin;
      endcase
    end
  end

  // Combinational register read mux.
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_CTRL:     w_rdata[5:2] = r_cfg;
      ADDR_CARRIER:  w_rdata[CARRIER_W-1:0] = r_carrier;
      ADDR_PRESCALE: w_rdata[PRESCALE_W-1:0] = r_prescale;
      ADDR_STATUS: begin
        w_rdata[STS_BUSY]  = w_busy;
        w_rdata[STS_EMPTY] = w_empty;
        w_rdata[STS_FULL]  = w_full;
        w_rdata[STS_OVF]   = r_ovf;
        w_rdata[STS_DONE]  = r_done;
        w_rdata[STS_LOW]   = w_low;
        w_rdata[STS_COUNT_LSB +: 6] = 6'(w_count);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hx2003_pulse_seq_tx.sv
// Directed bench for hx2003_pulse_seq_tx with a symbol-level waveform model.
module tb_hx2003_pulse_seq_tx;
  import hx2003_pulse_pkg::*;

  typedef struct packed {
    logic        lvl;
    logic        car;
    logic [11:0] dur;
  } sym_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned hi_total = 0;
  logic [1:0]  exp_q[$];
  sym_t        sym_q[$];

  always #5 clk = ~clk;

  hx2003_pulse_seq_tx #(
    .DEPTH (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    address = a;
    data_in = d;
    data_write_n = sz;
    @(posedge clk);
    #1;
    data_write_n = BUS_NONE;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    address = a;
    data_read_n = BUS_W32;
    #1;
    chk(nm, data_out, exp);
    data_read_n = BUS_NONE;
  endtask

  task automatic model_push(input logic lvl, input logic car, input logic [11:0] dur);
    if (sym_q.size() < 8) sym_q.push_back('{lvl: lvl, car: car, dur: dur});
  endtask

  task automatic dut_push(input logic lvl, input logic car, input logic [11:0] dur);
    wr(ADDR_FIFO, {16'b0, lvl, car, 2'b00, dur}, BUS_W32);
  endtask

  task automatic push(input logic lvl, input logic car, input logic [11:0] dur);
    model_push(lvl, car, dur);
    dut_push(lvl, car, dur);
  endtask

  // Expected {pin, busy} for every cycle after a START write, from the symbol
  // list: two lead-in cycles, max(D,1)*(P+1) cycles per symbol, one held
  // cycle per reload between symbols, then one idle cycle.
  task automatic build_wave(input int unsigned n, input int unsigned p,
                            input logic inv, input logic idle);
    logic ip;
    logic v;
    int unsigned d;
    int unsigned len;
    ip = idle ^ inv;
    v = ip;
    exp_q.push_back({ip, 1'b0});
    exp_q.push_back({ip, 1'b1});
    for (int k = 0; k < sym_q.size(); k++) begin
      d = (sym_q[k].dur == 12'd0) ? 1 : int'(sym_q[k].dur);
      len = d * (p + 1);
      for (int unsigned i = 0; i < len; i++) begin
        v = (sym_q[k].lvl & (sym_q[k].car ? (((i / (n + 1)) % 2) == 0) : 1'b1)) ^ inv;
        exp_q.push_back({v, 1'b1});
      end
      if (k + 1 < sym_q.size()) exp_q.push_back({v, 1'b1});
    end
    exp_q.push_back({ip, 1'b0});
    sym_q.delete();
  endtask

  task automatic compare_loop();
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (uo_out[7] === 1'b1) hi_total++;
        if (uo_out[7:6] !== e) begin
          n_err++;
          $display("FAIL wave: uo_out[7:6]=%b expected %b at %0t", uo_out[7:6], e, $time);
        end
      end
    end
  endtask

  task automatic drain(input int unsigned budget, input string nm);
    for (int unsigned i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int unsigned h0;
    int unsigned n;
    rst = 1'b1;
    ui_in = '0;
    address = '0;
    data_in = '0;
    data_write_n = BUS_NONE;
    data_read_n = BUS_NONE;
    fork
      compare_loop();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_uo", {24'b0, uo_out}, 32'h0);
    chk("rst_irq", {31'b0, user_interrupt}, 32'h0);
    chk("ready", {31'b0, data_ready}, 32'h1);
    rd(ADDR_CTRL, 32'h0, "rst_ctrl");
    rd(ADDR_CARRIER, 32'h0, "rst_carrier");
    rd(ADDR_PRESCALE, 32'h0, "rst_prescale");
    rd(ADDR_FIFO, 32'h0, "rst_fifo");
    rd(ADDR_STATUS, 32'h2, "rst_status");
    rd(6'h3C, 32'h0, "undef_addr");

    // Byte lanes and START on an empty FIFO
    wr(ADDR_PRESCALE, 32'h0000_1234, BUS_W32);
    wr(ADDR_PRESCALE, 32'hABCD_EFFF, BUS_W8);
    rd(ADDR_PRESCALE, 32'h0000_12FF, "lane8");
    wr(ADDR_CARRIER, 32'h5555_AAAA, BUS_W16);
    rd(ADDR_CARRIER, 32'h0000_AAAA, "lane16");
    wr(ADDR_CTRL, 32'h1, BUS_W8);
    rd(ADDR_STATUS, 32'h2, "start_empty");
    chk("start_empty_busy", {31'b0, uo_out[6]}, 32'h0);

    // Carrier N=3, P=0, one 16-tick symbol
    wr(ADDR_CARRIER, 32'd3, BUS_W32);
    wr(ADDR_PRESCALE, 32'd0, BUS_W32);
    push(1'b1, 1'b1, 12'd16);
    h0 = hi_total;
    wr(ADDR_CTRL, 32'h1, BUS_W8);
    build_wave(3, 0, 1'b0, 1'b0);
    drain(200, "drain_carrier");
    chk("carrier_hi_cycles", hi_total - h0, 8);
    rd(ADDR_STATUS, 32'h12, "carrier_done");
    wr(ADDR_STATUS, 32'h10, BUS_W8);
    rd(ADDR_STATUS, 32'h02, "done_clr");

    // P=9, three plain symbols, DONE interrupt
    wr(ADDR_PRESCALE, 32'd9, BUS_W32);
    push(1'b1, 1'b0, 12'd5);
    push(1'b0, 1'b0, 12'd3);
    push(1'b1, 1'b0, 12'd1);
    h0 = hi_total;
    wr(ADDR_CTRL, 32'h11, BUS_W8);
    build_wave(3, 9, 1'b0, 1'b0);
    drain(300, "drain_seq3");
    chk("seq3_hi_cycles", hi_total - h0, 61);
    chk("irq_done", {31'b0, user_interrupt}, 32'h1);
    wr(ADDR_STATUS, 32'h10, BUS_W8);
    chk("irq_done_clr", {31'b0, user_interrupt}, 32'h0);

    // Overflow: 9 pushes into 8 entries
    wr(ADDR_PRESCALE, 32'd0, BUS_W32);
    for (int i = 0; i < 9; i++) push(1'(i % 2), 1'b0, 12'd2);
    rd(ADDR_STATUS, 32'h80C, "ovf_full");
    h0 = hi_total;
    wr(ADDR_CTRL, 32'h1, BUS_W8);
    build_wave(3, 0, 1'b0, 1'b0);
    drain(200, "drain_ovf");
    chk("ovf_hi_cycles", hi_total - h0, 11);
    rd(ADDR_STATUS, 32'h1A, "ovf_after");
    wr(ADDR_STATUS, 32'h08, BUS_W8);
    rd(ADDR_STATUS, 32'h12, "ovf_clr");
    wr(ADDR_STATUS, 32'h10, BUS_W8);

    // Low watermark with refill during RUN
    wr(ADDR_PRESCALE, 32'd4, BUS_W32);
    wr(ADDR_CTRL, 32'h20, BUS_W8);
    for (int i = 0; i < 4; i++) push(1'(i % 2 == 0), 1'b0, 12'd4);
    model_push(1'b1, 1'b0, 12'd4);
    model_push(1'b0, 1'b0, 12'd4);
    rd(ADDR_STATUS, 32'h400, "low_queued");
    chk("low_irq_idle", {31'b0, user_interrupt}, 32'h0);
    wr(ADDR_CTRL, 32'h21, BUS_W8);
    build_wave(3, 4, 1'b0, 1'b0);
    chk("low_irq_start", {31'b0, user_interrupt}, 32'h0);
    n = 0;
    while (!user_interrupt && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("low_irq_cycle", n, 23);
    rd(ADDR_STATUS, 32'h221, "low_status");
    dut_push(1'b1, 1'b0, 12'd4);
    dut_push(1'b0, 1'b0, 12'd4);
    chk("low_irq_refill", {31'b0, user_interrupt}, 32'h0);
    drain(400, "drain_low");
    rd(ADDR_STATUS, 32'h12, "low_done");
    wr(ADDR_STATUS, 32'h10, BUS_W8);

    // ABORT mid-RUN with INVERT=1, IDLE_LVL=0
    wr(ADDR_PRESCALE, 32'd0, BUS_W32);
    wr(ADDR_CTRL, 32'h08, BUS_W8);
    push(1'b1, 1'b0, 12'd20);
    push(1'b1, 1'b0, 12'd20);
    wr(ADDR_CTRL, 32'h09, BUS_W8);
    sym_q.delete();
    repeat (10) @(negedge clk);
    chk("abort_run_uo", {24'b0, uo_out}, 32'h40);
    wr(ADDR_CTRL, 32'h0A, BUS_W8);
    chk("abort_uo", {24'b0, uo_out}, 32'h80);
    rd(ADDR_STATUS, 32'h02, "abort_status");
    rd(ADDR_CTRL, 32'h08, "abort_ctrl");

    // Reset pulse mid-RUN
    wr(ADDR_CARRIER, 32'd7, BUS_W32);
    push(1'b1, 1'b1, 12'd20);
    push(1'b0, 1'b0, 12'd20);
    wr(ADDR_CTRL, 32'h09, BUS_W8);
    sym_q.delete();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_run_uo", {24'b0, uo_out}, 32'h0);
    chk("rst_run_irq", {31'b0, user_interrupt}, 32'h0);
    rd(ADDR_CTRL, 32'h0, "rst_run_ctrl");
    rd(ADDR_CARRIER, 32'h0, "rst_run_carrier");
    rd(ADDR_PRESCALE, 32'h0, "rst_run_prescale");
    rd(ADDR_STATUS, 32'h2, "rst_run_status");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
